// File: rtl/obsidian_pipe_pkg.sv
// obsidian_pipe_pkg: shared stage-boundary widths and occupancy sizing for Obsidian pipes
package obsidian_pipe_pkg;
  localparam int IF_ID_W = 64;
  localparam int ID_EX_W = 157;
  localparam int EX_MEM_W = 107;
  localparam int MEM_WB_W = 71;
  localparam int WB_ID_W = 38;
  function automatic int occ_width(input int stages, input int skid);
    return $clog2(stages * (1 + skid) + 1);
  endfunction
endpackage

// File: rtl/obsidian_pipe_slot.sv
// obsidian_pipe_slot: one elastic register slot, optionally with a skid entry
module obsidian_pipe_slot
  import obsidian_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              up_valid_i,
  input  logic              up_ready_i,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              dn_ready_i,
  output logic              v_o,
  output logic              sv_o,
  output logic [DATA_W-1:0] dn_data_o
);
  logic v_q, v_d, up_acc, dn_acc;
  logic [DATA_W-1:0] d_q, d_d;
  assign v_o = v_q;
  assign dn_data_o = d_q;
  assign up_acc = up_valid_i & up_ready_i;
  assign dn_acc = v_q & dn_ready_i & ~flush_i;
  if (SKID != 0) begin : g_skid
    logic sv_q, sv_d, take;
    logic [DATA_W-1:0] sd_q, sd_d;
    assign sv_o = sv_q;
    always_comb begin
      take = ~sv_q & (~v_q | dn_acc);
      v_d = ~flush_i & (sv_q | ~take | up_acc);
      sv_d = ~flush_i & (sv_q ? ~dn_acc : (~take & up_acc));
      d_d = (sv_q & dn_acc) ? sd_q : (take & up_acc) ? up_data_i : d_q;
      sd_d = (~take & up_acc) ? up_data_i : sd_q;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        sv_q <= 1'b0;
        sd_q <= '0;
      end else begin
        sv_q <= sv_d;
        sd_q <= sd_d;
      end
    end
  end else begin : g_plain
    assign sv_o = 1'b0;
    always_comb begin
      v_d = ~flush_i & (up_acc | (v_q & ~dn_ready_i));
      d_d = up_acc ? up_data_i : d_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end
endmodule

// File: rtl/obsidian_elastic_pipe.sv
// obsidian_elastic_pipe: STAGES elastic slots in series with flush and occupancy count
module obsidian_elastic_pipe
  import obsidian_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 1,
  parameter int SKID = 1,
  localparam int OCC_W = occ_width(STAGES, SKID)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int MAX_OCC = STAGES * (1 + SKID);
  logic [STAGES-1:0] v, sv;
  logic [STAGES:0] val, rdy;
  logic [DATA_W-1:0] dat [STAGES+1];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic in_acc, out_acc;
  assign dat[0] = in_data;
  assign val = {v & ~{STAGES{flush}}, in_valid};
  // Readiness derives only from held valid bits, so the SKID=0 chain never loops on itself
  always_comb begin
    logic c;
    c = out_ready;
    rdy = {out_ready, {STAGES{1'b0}}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      c = (SKID != 0) ? ~sv[i] : (~v[i] | c);
      rdy[i] = c & ~flush;
    end
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    obsidian_pipe_slot #(.DATA_W(DATA_W), .SKID(SKID)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .up_valid_i(val[g]),
      .up_ready_i(rdy[g]),
      .up_data_i (dat[g]),
      .dn_ready_i(rdy[g+1]),
      .v_o       (v[g]),
      .sv_o      (sv[g]),
      .dn_data_o (dat[g+1])
    );
  end
  assign in_ready = rdy[0];
  assign out_valid = val[STAGES];
  assign out_data = dat[STAGES];
  assign occupancy = occ_q;
  assign in_acc = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  always_comb occ_d = flush ? '0 : occ_q + OCC_W'(in_acc) - OCC_W'(out_acc);
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else occ_q <= occ_d;
  end
  a_flush_empty: assert property (@(posedge clk) disable iff (rst) flush |=> !out_valid);
  a_occ: assert property (@(posedge clk) disable iff (rst)
    (int'(occupancy) <= MAX_OCC) && (int'(occupancy) == $countones({v, sv})));
endmodule
